t08_touch_event_decoder: RTL and testbench

- Sits directly downstream of the team's I2C touchscreen master: consumes its 32-bit packet and one-cycle done pulse.
- Decodes each packet into X/Y coordinates, touch ID and event type.
- Tracks press/contact/lift with a state machine, suppresses sub-threshold jitter and synthesises a release if the lift packet is lost.
- Presents PRESS/MOVE/RELEASE events to the CPU-side consumer over a valid/ready handshake.

---
 rtl/t08_touch_pkg.sv | 50 +++++
 rtl/t08_touch_out_reg.sv | 64 ++++++
 rtl/t08_touch_event_decoder.sv | 172 +++++++++++++++++
 tb/tb_t08_touch_event_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t08_touch_pkg.sv
// Shared types and constants for the touch event decoder: packet layout,
// raw controller event codes, presented event encoding and the event payload.
package t08_touch_pkg;

  localparam int unsigned PKT_W   = 32;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned RAW_W   = 2;

  // Packet bit positions (LSB of each field)
  localparam int unsigned PKT_EV_LSB = 30;
  localparam int unsigned PKT_X_LSB  = 16;
  localparam int unsigned PKT_ID_LSB = 12;
  localparam int unsigned PKT_Y_LSB  = 0;

  localparam logic [RAW_W-1:0] RAW_DOWN    = 2'b00;
  localparam logic [RAW_W-1:0] RAW_LIFT    = 2'b01;
  localparam logic [RAW_W-1:0] RAW_CONTACT = 2'b10;
  localparam logic [RAW_W-1:0] RAW_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_MOVE    = 2'b10,
    EV_RELEASE = 2'b11
  } touch_event_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_TOUCHING = 1'b1
  } touch_state_t;

  typedef struct packed {
    touch_event_t       ev;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ID_W-1:0]    id;
  } touch_evt_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/t08_touch_out_reg.sv
// Single-entry valid/ready event holding register. A pending MOVE may be
// replaced by a newer MOVE/RELEASE; anything else arriving while full is dropped.
module t08_touch_out_reg
  import t08_touch_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       i_ev_vld,
  input  touch_evt_t i_ev,
  input  logic       i_ready,
  output logic       o_valid,
  output touch_evt_t o_ev,
  output logic       o_overflow
);

  logic       r_valid;
  touch_evt_t r_ev;
  logic       r_overflow;

  logic w_hs;
  logic w_load;
  logic w_coalesce;
  logic w_drop;

  always_comb begin
    w_hs       = r_valid && i_ready;
    w_load     = 1'b0;
    w_coalesce = 1'b0;
    w_drop     = 1'b0;
    if (i_ev_vld) begin
      if (!r_valid || w_hs) begin
        w_load = 1'b1;
      end else if (r_ev.ev == EV_MOVE && i_ev.ev != EV_PRESS) begin
        w_coalesce = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_valid    <= 1'b0;
      r_ev       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load || w_coalesce) begin
        r_valid <= 1'b1;
        r_ev    <= i_ev;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      // Sticky until reset
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_ev       = r_ev;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/t08_touch_event_decoder.sv
// Touch packet decoder: press/contact/lift tracking, jitter suppression and
// lost-lift timeout. Define T08_TOUCH_SWAP_XY_EN for a rotated panel (X/Y swapped).
module t08_touch_event_decoder
  import t08_touch_pkg::*;
#(
  parameter int unsigned MOVE_THRESH    = 4,
  parameter int unsigned X_MAX          = 319,
  parameter int unsigned Y_MAX          = 479,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [PKT_W-1:0]   pkt_data,
  input  logic               pkt_done,
  output logic               touch_valid,
  input  logic               touch_ready,
  output logic [1:0]         touch_event,
  output logic [COORD_W-1:0] touch_x,
  output logic [COORD_W-1:0] touch_y,
  output logic [ID_W-1:0]    touch_id,
  output logic               touching,
  output logic               overflow
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  touch_state_t r_state;
  touch_state_t w_state_nxt;

  logic               r_touching;
  logic [COORD_W-1:0] r_last_x;
  logic [COORD_W-1:0] r_last_y;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;

  logic [RAW_W-1:0]   w_raw;
  logic [COORD_W-1:0] w_x_raw;
  logic [COORD_W-1:0] w_y_raw;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [ID_W-1:0]    w_id;
  logic               w_unused_bits;

  logic               w_accept;
  logic               w_expire;
  logic               w_moved;
  logic               w_gen;
  touch_evt_t         w_gen_evt;
  logic               w_latch_xy;
  logic               w_latch_id;
  logic [CNT_W-1:0]   w_cnt_nxt;

  touch_evt_t         w_out_ev;

  assign w_raw         = pkt_data[PKT_EV_LSB +: RAW_W];
  assign w_id          = pkt_data[PKT_ID_LSB +: ID_W];
  assign w_unused_bits = ^pkt_data[PKT_EV_LSB-1 -: 2];

`ifdef T08_TOUCH_SWAP_XY_EN
  assign w_x_raw = pkt_data[PKT_Y_LSB +: COORD_W];
  assign w_y_raw = pkt_data[PKT_X_LSB +: COORD_W];
`else
  assign w_x_raw = pkt_data[PKT_X_LSB +: COORD_W];
  assign w_y_raw = pkt_data[PKT_Y_LSB +: COORD_W];
`endif

  assign w_x = clamp_coord(w_x_raw, COORD_W'(X_MAX));
  assign w_y = clamp_coord(w_y_raw, COORD_W'(Y_MAX));

  // Reserved raw events are invisible: they neither advance the FSM nor reset the timer
  assign w_accept = pkt_done && (w_raw != RAW_RSVD);
  assign w_expire = (r_state == ST_TOUCHING) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_moved  = (abs_diff(w_x, r_last_x) >= COORD_W'(MOVE_THRESH)) ||
                    (abs_diff(w_y, r_last_y) >= COORD_W'(MOVE_THRESH));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gen        = 1'b0;
    w_gen_evt.ev = EV_NONE;
    w_gen_evt.x  = w_x;
    w_gen_evt.y  = w_y;
    w_gen_evt.id = w_id;
    w_latch_xy   = 1'b0;
    w_latch_id   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_raw == RAW_DOWN || w_raw == RAW_CONTACT)) begin
          w_gen        = 1'b1;
          w_gen_evt.ev = EV_PRESS;
          w_latch_xy   = 1'b1;
          w_latch_id   = 1'b1;
          w_state_nxt  = ST_TOUCHING;
        end
      end
      ST_TOUCHING: begin
        if (w_accept) begin
          if (w_raw == RAW_LIFT) begin
            w_gen        = 1'b1;
            w_gen_evt.ev = EV_RELEASE;
            w_state_nxt  = ST_IDLE;
          end else if (w_moved) begin
            w_gen        = 1'b1;
            w_gen_evt.ev = EV_MOVE;
            w_latch_xy   = 1'b1;
          end
        end else if (w_expire) begin
          // Lift packet presumed lost: release where the finger was last seen
          w_gen        = 1'b1;
          w_gen_evt.ev = EV_RELEASE;
          w_gen_evt.x  = r_last_x;
          w_gen_evt.y  = r_last_y;
          w_gen_evt.id = r_id;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (r_state == ST_IDLE || w_accept || w_expire) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_touching <= 1'b0;
      r_last_x   <= '0;
      r_last_y   <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
    end else begin
      r_touching <= (w_state_nxt == ST_TOUCHING);
      r_cnt      <= w_cnt_nxt;
      if (w_latch_xy) begin
        r_last_x <= w_x;
        r_last_y <= w_y;
      end
      if (w_latch_id) begin
        r_id <= w_id;
      end
    end
  end

  t08_touch_out_reg u_out_reg (
    .clk        (clk),
    .nRst       (nRst),
    .i_ev_vld   (w_gen),
    .i_ev       (w_gen_evt),
    .i_ready    (touch_ready),
    .o_valid    (touch_valid),
    .o_ev       (w_out_ev),
    .o_overflow (overflow)
  );

  assign touch_event = w_out_ev.ev;
  assign touch_x     = w_out_ev.x;
  assign touch_y     = w_out_ev.y;
  assign touch_id    = w_out_ev.id;
  assign touching    = r_touching;

endmodule

// File: tb/tb_t08_touch_event_decoder.sv
// Scoreboard bench for t08_touch_event_decoder: directed scenarios plus random
// packets against a behavioural model of the touch protocol.
module tb_t08_touch_event_decoder;

  localparam int TMO = 100;
  localparam int XM  = 319;
  localparam int YM  = 479;
  localparam int THR = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [31:0] pkt_data = '0;
  logic        pkt_done = 1'b0;
  logic        touch_ready = 1'b0;
  logic        touch_valid;
  logic [1:0]  touch_event;
  logic [11:0] touch_x;
  logic [11:0] touch_y;
  logic [3:0]  touch_id;
  logic        touching;
  logic        overflow;

  t08_touch_event_decoder #(
    .MOVE_THRESH    (THR),
    .X_MAX          (XM),
    .Y_MAX          (YM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .pkt_data    (pkt_data),
    .pkt_done    (pkt_done),
    .touch_valid (touch_valid),
    .touch_ready (touch_ready),
    .touch_event (touch_event),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .touch_id    (touch_id),
    .touching    (touching),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int ev; int x; int y; int id; } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Model: finger state, last reported position, pending consumer slot
  bit   m_touch, m_valid, m_ovf;
  int   m_lx, m_ly, m_id, m_deadline, edge_no;
  exp_t m_slot;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int clampv(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [31:0] mk(int raw, int x, int y, int id);
    return {2'(raw), 2'b00, 12'(x), 4'(id), 12'(y)};
  endfunction

  task automatic model_reset();
    m_touch = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
    m_lx = 0; m_ly = 0; m_id = 0; m_deadline = 0;
    m_slot = '{0, 0, 0, 0};
  endtask

  task automatic model_edge(bit done, logic [31:0] d, bit rdy);
    int   raw, x, y, id;
    bit   gen, hs;
    exp_t e;
    hs  = m_valid && rdy;
    gen = 1'b0;
    e   = '{0, 0, 0, 0};
    raw = int'(d[31:30]);
`ifdef T08_TOUCH_SWAP_XY_EN
    x = clampv(int'(d[11:0]), XM);
    y = clampv(int'(d[27:16]), YM);
`else
    x = clampv(int'(d[27:16]), XM);
    y = clampv(int'(d[11:0]), YM);
`endif
    id = int'(d[15:12]);
    if (done && raw != 3) begin
      if (!m_touch) begin
        if (raw != 1) begin
          gen = 1'b1; e = '{1, x, y, id};
          m_touch = 1'b1; m_lx = x; m_ly = y; m_id = id;
          m_deadline = edge_no + TMO;
        end
      end else begin
        m_deadline = edge_no + TMO;
        if (raw == 1) begin
          gen = 1'b1; e = '{3, x, y, id}; m_touch = 1'b0;
        end else if (absd(x, m_lx) >= THR || absd(y, m_ly) >= THR) begin
          gen = 1'b1; e = '{2, x, y, id}; m_lx = x; m_ly = y;
        end
      end
    end else if (m_touch && edge_no == m_deadline) begin
      gen = 1'b1; e = '{3, m_lx, m_ly, m_id}; m_touch = 1'b0;
    end
    if (gen) begin
      if (!m_valid || hs) begin
        m_valid = 1'b1; m_slot = e;
      end else if (m_slot.ev == 2 && e.ev != 1) begin
        m_slot = e;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs, queue the event the consumer will take, advance model
  task automatic step(bit done, logic [31:0] d, bit rdy);
    pkt_done    = done;
    pkt_data    = d;
    touch_ready = rdy;
    if (m_valid && rdy) sb.push_back(m_slot);
    @(posedge clk);
    #1;
    edge_no++;
    model_edge(done, d, rdy);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, rdy);
  endtask

  task automatic check_reset();
    chk("rst_valid", touch_valid, 0);
    chk("rst_event", touch_event, 0);
    chk("rst_x", touch_x, 0);
    chk("rst_y", touch_y, 0);
    chk("rst_id", touch_id, 0);
    chk("rst_touching", touching, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    pkt_done = 1'b1;
    pkt_data = mk(0, 7, 7, 1);
    nRst = 1'b0;
    #2;
    check_reset();
    @(posedge clk);
    #1;
    pkt_done = 1'b0;
    nRst = 1'b1;
    model_reset();
    sb.delete();
    mon_en = 1'b1;
  endtask

  task automatic random_phase(int n, int rdy_pct);
    int r, raw, x, y;
    bit dn;
    for (int i = 0; i < n; i++) begin
      r   = int'($urandom_range(0, 99));
      dn  = (r < 35);
      raw = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        x = int'($urandom_range(0, 4095));
        y = int'($urandom_range(0, 4095));
      end else begin
        x = m_lx + int'($urandom_range(0, 10)) - 5;
        y = m_ly + int'($urandom_range(0, 10)) - 5;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
      end
      step(dn, mk(raw, x, y, int'($urandom_range(0, 15))),
           int'($urandom_range(0, 99)) < rdy_pct);
    end
  endtask

  // Monitor: per-cycle state checks, scoreboard pop on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("touch_valid", touch_valid, m_valid);
      chk("touching", touching, m_touch);
      chk("overflow", overflow, m_ovf);
      if (m_valid) begin
        chk("held_event", touch_event, m_slot.ev);
        chk("held_x", touch_x, m_slot.x);
        chk("held_y", touch_y, m_slot.y);
        chk("held_id", touch_id, m_slot.id);
      end
      if (touch_valid && touch_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_event actual=%0d expected=none at %0t", touch_event, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_event", touch_event, e.ev);
          chk("sb_x", touch_x, e.x);
          chk("sb_y", touch_y, e.y);
          chk("sb_id", touch_id, e.id);
        end
      end
    end
  end

  initial begin
    model_reset();
    edge_no = 0;
    nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    nRst = 1'b1;
    mon_en = 1'b1;

    // Press, jitter, move, lift, stray lift
    step(1'b1, 32'h0064_00C8, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, mk(2, 102, 201, 0), 1'b1);
    step(1'b1, mk(2, 110, 200, 0), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h406E_00C8, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h406E_00C8, 1'b1);
    idle(2, 1'b1);
    chk("idle_after_release", touching, 0);

    // Clamp on press, then lift
    step(1'b1, mk(0, 4000, 4000, 3), 1'b1);
    step(1'b0, '0, 1'b0);
    chk("clamp_x", touch_x, XM);
    chk("clamp_y", touch_y, YM);
    step(1'b1, mk(1, 4000, 4000, 3), 1'b1);
    idle(2, 1'b1);

    // Back-pressure: drop onto held PRESS, then coalesce MOVE/MOVE/RELEASE
    step(1'b1, mk(0, 50, 50, 1), 1'b0);
    step(1'b1, mk(2, 60, 50, 1), 1'b0);
    step(1'b1, mk(2, 70, 50, 1), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("press_held", touch_event, 1);
    step(1'b0, '0, 1'b1);
    step(1'b1, mk(2, 80, 50, 1), 1'b0);
    step(1'b1, mk(2, 90, 50, 1), 1'b0);
    step(1'b1, mk(1, 95, 55, 1), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("coalesced_release", touch_event, 3);
    idle(3, 1'b1);

    do_reset();

    // Timeout: synthetic release at the last position
    step(1'b1, mk(0, 20, 30, 5), 1'b1);
    idle(TMO + 5, 1'b1);
    chk("timeout_idle", touching, 0);

    // Packet landing exactly on the expiry cycle wins, twice
    step(1'b1, mk(0, 40, 40, 6), 1'b1);
    idle(TMO - 1, 1'b1);
    step(1'b1, mk(2, 41, 40, 6), 1'b1);
    idle(TMO - 1, 1'b1);
    chk("expiry_packet_wins", touching, 1);
    step(1'b1, mk(1, 42, 41, 6), 1'b1);
    idle(3, 1'b1);

    random_phase(1500, 70);
    idle(TMO + 5, 1'b1);
    do_reset();
    random_phase(800, 95);
    idle(TMO + 5, 1'b1);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
